// File: rtl/franken_uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// FSM encoding, data width and baud divider helper.
package franken_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with drop-on-full writes.
// A write into a full FIFO is still accepted when a read frees a slot that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_rd;
  logic             do_wr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  assign ovf   = wr & full & ~do_rd;
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// tx and busy are registered one cycle behind the FSM state.
module uart_tx_fifo
  import franken_uart_pkg::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

  state_t               state;
  state_t               next;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 tick;
  logic                 pop;
  logic                 ovf;
  logic                 tx_d;
  logic                 busy_d;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_en),
    .wdata (wr_data),
    .rd    (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count),
    .ovf   (ovf)
  );

  assign tick = (baud_cnt == CW'(CPB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    pop  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          next = START;
          pop  = 1'b1;
        end
      end
      START: begin
        if (tick) next = DATA;
      end
      DATA: begin
        if (tick && bit_idx == 3'(DATA_BITS - 1)) next = STOP;
      end
      STOP: begin
        if (tick) begin
          if (!empty) begin
            next = START;
            pop  = 1'b1;
          end else begin
            next = IDLE;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state != IDLE) | ~empty;
    unique case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (pop || state == IDLE || tick) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + CW'(1);
      if (pop) shift <= head;
      if (state == START && tick) bit_idx <= '0;
      if (state == DATA && tick) begin
        bit_idx <= bit_idx + 3'd1;
        shift   <= shift >> 1;
      end
    end
  end

  // Dropped write wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx   <= tx_d;
      busy <= busy_d;
      if (ovf)          overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a scoreboard fed by a line receiver.
// Three instances: fast 16-deep, fast 4-deep, and default baud settings.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  wr_en;
  logic [2:0]  clr_ovf;
  logic [7:0]  wr_data [3];
  logic [2:0]  tx, full, empty, busy, overflow;
  logic [4:0]  count_a, count_c;
  logic [2:0]  count_b;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int nframes [3];
  int starts [3][64];

  logic [7:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .clr_ovf(clr_ovf[0]), .tx(tx[0]), .full(full[0]), .empty(empty[0]),
    .count(count_a), .busy(busy[0]), .overflow(overflow[0])
  );

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .clr_ovf(clr_ovf[1]), .tx(tx[1]), .full(full[1]), .empty(empty[1]),
    .count(count_b), .busy(busy[1]), .overflow(overflow[1])
  );

  uart_tx_fifo dut_c (
    .clk(clk), .reset(reset), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
    .clr_ovf(clr_ovf[2]), .tx(tx[2]), .full(full[2]), .empty(empty[2]),
    .count(count_c), .busy(busy[2]), .overflow(overflow[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input int s, input logic [7:0] b);
    case (s)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  function automatic int qsize(input int s);
    case (s)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int s);
    case (s)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Line receiver: every cycle of a bit must equal that bit's first cycle.
  task automatic rx_mon(input int s);
    int cpb, st, bad;
    logic ab, first;
    logic [9:0] fr;
    cpb = (s == 2) ? 234 : 10;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx[s] !== 1'b0) continue;
      st = cyc; bad = 0; ab = 1'b0; fr = '0; first = 1'b0;
      for (int i = 0; i < 10 * cpb; i++) begin
        if (i > 0) @(negedge clk);
        if (reset !== 1'b0) begin ab = 1'b1; break; end
        if (i % cpb == 0) begin
          first = tx[s];
          fr[i / cpb] = tx[s];
        end else if (tx[s] !== first) begin
          bad++;
        end
      end
      if (!ab) begin
        starts[s][nframes[s]] = st;
        nframes[s]++;
        chk("rx_start_bit", 32'(fr[0]), 32'd0);
        chk("rx_stop_bit", 32'(fr[9]), 32'd1);
        chk("rx_bit_width", bad, 0);
        chk("rx_expected_frame", (qsize(s) > 0) ? 1 : 0, 1);
        if (qsize(s) > 0) chk("rx_data", 32'(fr[8:1]), 32'(qpop(s)));
      end
    end
  endtask

  initial rx_mon(0);
  initial rx_mon(1);
  initial rx_mon(2);

  task automatic send(input int s, input logic [7:0] b, input bit ok);
    wr_en[s] = 1'b1;
    wr_data[s] = b;
    @(negedge clk);
    wr_en[s] = 1'b0;
    if (ok) push(s, b);
  endtask

  task automatic wait_busy_fall(input int s, input int lim, output int fc);
    int n;
    n = 0;
    while (busy[s] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("busy_rise", 32'(busy[s]), 32'd1);
    n = 0;
    while (busy[s] !== 1'b0 && n < lim) begin @(negedge clk); n++; end
    chk("busy_fall", 32'(busy[s]), 32'd0);
    fc = cyc;
  endtask

  task automatic wait_frames(input int s, input int target, input int lim,
                             output int st);
    int n;
    n = 0;
    while (nframes[s] < target && n < lim) begin @(negedge clk); n++; end
    chk("frame_seen", (nframes[s] >= target) ? 1 : 0, 1);
    st = (nframes[s] >= target) ? starts[s][target-1] : -1;
  endtask

  task automatic wait_drain(input int s, input int lim);
    int n;
    repeat (2) @(negedge clk);
    n = 0;
    while ((busy[s] !== 1'b0 || qsize(s) != 0) && n < lim) begin
      @(negedge clk); n++;
    end
    chk("drain_idle", 32'(busy[s]), 32'd0);
    chk("drain_queue", qsize(s), 0);
  endtask

  initial begin
    int wcyc, fc, s1, s2, s3, n0, k0, n;
    reset = 1'b1;
    wr_en = '0;
    clr_ovf = '0;
    for (int i = 0; i < 3; i++) begin
      wr_data[i] = '0;
      nframes[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_tx", 32'(tx), 32'h7);
    chk("rst_empty", 32'(empty), 32'h7);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_count_b", 32'(count_b), 32'd0);

    // single byte: latency, frame, busy fall
    n0 = nframes[0];
    send(0, 8'h55, 1'b1);
    wcyc = cyc;
    wait_busy_fall(0, 300, fc);
    wait_frames(0, n0 + 1, 50, s1);
    chk("t1_tx_latency", s1 - wcyc, 2);
    chk("t1_busy_fall", fc - wcyc, 102);
    chk("t1_queue_empty", qsize(0), 0);
    repeat (5) @(negedge clk);

    // burst of three: back-to-back frames
    n0 = nframes[0];
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b1);
    send(0, 8'hA5, 1'b1);
    wait_busy_fall(0, 500, fc);
    wait_frames(0, n0 + 1, 50, s1);
    wait_frames(0, n0 + 2, 50, s2);
    wait_frames(0, n0 + 3, 50, s3);
    chk("t2_gap_1_2", s2 - s1, 100);
    chk("t2_gap_2_3", s3 - s2, 100);
    chk("t2_total", fc - s1, 300);
    wait_drain(0, 100);

    // 4-deep FIFO: fill, overflow, clear, write-with-pop on full
    k0 = cyc;
    send(1, 8'h11, 1'b1);
    send(1, 8'h22, 1'b1);
    send(1, 8'h33, 1'b1);
    send(1, 8'h44, 1'b1);
    send(1, 8'h55, 1'b1);
    send(1, 8'h66, 1'b0);
    chk("t3_count_full", 32'(count_b), 32'd4);
    chk("t3_full", 32'(full[1]), 32'd1);
    chk("t3_overflow", 32'(overflow[1]), 32'd1);
    wr_en[1] = 1'b1;
    wr_data[1] = 8'h99;
    clr_ovf[1] = 1'b1;
    @(negedge clk);
    wr_en[1] = 1'b0;
    clr_ovf[1] = 1'b0;
    chk("t3_ovf_beats_clear", 32'(overflow[1]), 32'd1);
    chk("t3_count_after_drop", 32'(count_b), 32'd4);
    clr_ovf[1] = 1'b1;
    @(negedge clk);
    clr_ovf[1] = 1'b0;
    chk("t3_clr_ovf", 32'(overflow[1]), 32'd0);
    n = 0;
    while (cyc < k0 + 101 && n < 200) begin @(negedge clk); n++; end
    chk("t4_before_pop_full", 32'(full[1]), 32'd1);
    send(1, 8'h7E, 1'b1);
    chk("t4_count_same", 32'(count_b), 32'd4);
    chk("t4_no_overflow", 32'(overflow[1]), 32'd0);
    wait_drain(1, 800);

    // default baud settings
    n0 = nframes[2];
    send(2, 8'h41, 1'b1);
    wait_busy_fall(2, 3000, fc);
    wait_frames(2, n0 + 1, 50, s1);
    chk("t6_frame_len", fc - s1, 2340);
    wait_drain(2, 100);

    // reset mid-frame with a byte still queued
    n0 = nframes[0];
    send(0, 8'h3C, 1'b1);
    send(0, 8'hC3, 1'b1);
    n = 0;
    while (tx[0] !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("t5_frame_started", 32'(tx[0]), 32'd0);
    repeat (35) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_tx_high", 32'(tx[0]), 32'd1);
    chk("t5_empty", 32'(empty[0]), 32'd1);
    chk("t5_count", 32'(count_a), 32'd0);
    chk("t5_busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q0.delete();
    repeat (300) @(negedge clk);
    chk("t5_no_frame", nframes[0], n0);
    chk("t5_idle_tx", 32'(tx[0]), 32'd1);

    // recovers after reset
    send(0, 8'h81, 1'b1);
    wait_drain(0, 200);
    chk("t5_recovered", nframes[0], n0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
